// File: rtl/press_arbiter_pkg.sv
// Shared definitions for the key-press arbiter: state encoding, key-to-player map, timer defaults.
package press_arbiter_pkg;

    localparam int unsigned N_KEYS_DEF        = 4;
    localparam int unsigned ID_W              = 2;
    localparam int unsigned CNT_W             = 8;
    localparam int unsigned LOCKOUT_TICKS_DEF = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        GRANT   = 2'd2,
        LOCKOUT = 2'd3
    } state_e;

    // Keys 0-1 belong to player 1 (0), keys 2-3 to player 2 (1)
    localparam logic [3:0] PLAYER_OF_KEY = 4'b1100;

    function automatic logic player_of(input logic [ID_W-1:0] id);
        return PLAYER_OF_KEY[id];
    endfunction

endpackage

// File: rtl/press_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at or after rr, wrapping modulo 4.
module press_arbiter_rr_pick4
    import press_arbiter_pkg::*;
(
    input  logic [3:0]      elig,
    input  logic [ID_W-1:0] rr,
    output logic [ID_W-1:0] win_id,
    output logic            any
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset back to rr so the nearest candidate wins
    always_comb begin
        win_id = rr;
        any    = 1'b0;
        idx    = rr;
        for (int k = 3; k >= 0; k--) begin
            idx = rr + ID_W'(k);
            if (elig[idx]) begin
                win_id = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/press_arbiter.sv
// Turns debounced key levels into single round-robin press grants with post-grant lockout and foul masking.
module press_arbiter
    import press_arbiter_pkg::*;
#(
    parameter int unsigned N_KEYS         = N_KEYS_DEF,
    parameter int unsigned LOCKOUT_TICKS  = LOCKOUT_TICKS_DEF,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    input  logic              tick,
    input  logic              enable,
    output logic              grant_valid,
    output logic [ID_W-1:0]   grant_id,
    output logic              grant_player,
    input  logic              grant_ready,
    output logic              lockout,
    output logic [1:0]        foul
);

    state_e             state_q, state_d;
    logic [N_KEYS-1:0]  key_q, key_n;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         foul_q, foul_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic               gpl_q, gpl_d;
    logic               gvalid_q, gvalid_d;
    logic               lock_q, lock_d;
    logic [N_KEYS-1:0]  press, foul_exp, elig;
    logic [ID_W-1:0]    win_id;
    logic               win_any;

    press_arbiter_rr_pick4 u_pick (
        .elig   (elig),
        .rr     (rr_q),
        .win_id (win_id),
        .any    (win_any)
    );

    always_comb begin
        key_n    = KEY_ACTIVE_LOW ? ~key : key;
        press    = key_n & ~key_q;
        foul_exp = {{2{foul_q[1]}}, {2{foul_q[0]}}};
        elig     = press & ~foul_exp;

        state_d = state_q;
        cnt_d   = cnt_q;
        foul_d  = foul_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        gpl_d   = gpl_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            foul_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (win_any) begin
                        state_d = GRANT;
                        gid_d   = win_id;
                        gpl_d   = player_of(win_id);
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        rr_d   = gid_q + ID_W'(1);
                        foul_d = '0;
                        if (LOCKOUT_TICKS == 0) begin
                            state_d = ARMED;
                        end else begin
                            state_d = LOCKOUT;
                            cnt_d   = CNT_W'(LOCKOUT_TICKS);
                        end
                    end
                end
                LOCKOUT: begin
                    // Presses during lockout bar the offending player until the next accepted grant
                    foul_d = foul_q | {press[3] | press[2], press[1] | press[0]};
                    if (tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = ARMED;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        gvalid_d = (state_d == GRANT);
        lock_d   = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            key_q    <= '0;
            cnt_q    <= '0;
            foul_q   <= '0;
            rr_q     <= '0;
            gid_q    <= '0;
            gpl_q    <= 1'b0;
            gvalid_q <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_n;
            cnt_q    <= cnt_d;
            foul_q   <= foul_d;
            rr_q     <= rr_d;
            gid_q    <= gid_d;
            gpl_q    <= gpl_d;
            gvalid_q <= gvalid_d;
            lock_q   <= lock_d;
        end
    end

    assign grant_valid  = gvalid_q;
    assign grant_id     = gid_q;
    assign grant_player = gpl_q;
    assign lockout      = lock_q;
    assign foul         = foul_q;

endmodule

// File: doc/press_arbiter.md
# press_arbiter

Arbitrates the four debounced game keys into single, ordered press events for the game state machine. It sits between the debouncers and the top-level game FSM, in the 25 MHz pixel-clock domain. Each accepted press is issued as one grant over a valid/ready handshake. A frame-tick lockout follows every grant, and a per-player foul mask suppresses players who press during that lockout.

## Interface
Parameters:
- N_KEYS, 4: number of keys. Keys 0–1 belong to player 1 and keys 2–3 to player 2.
- LOCKOUT_TICKS, 30: length of the post-grant lockout, in frame ticks (30 ticks = 0.5 s at 60 Hz). Legal range 0–255.
- KEY_ACTIVE_LOW, 1: 1 means a key reads 0 when pressed.

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  reset. Asynchronous and active-high. One clock; reset is asynchronous and active-high.
- key  in  N_KEYS  debounced key levels.
- tick  in  1  one-cycle frame tick at 60 Hz.
- enable  in  1  arms the arbiter. Driven high by the game FSM in the play state.
- grant_valid  out  1  a press event is pending.
- grant_id  out  2  index of the granted key.
- grant_player  out  1  granted player: 0 = player 1, 1 = player 2.
- grant_ready  in  1  consumer accepts the grant.
- lockout  out  1  the arbiter is in the lockout state.
- foul  out  2  per-player foul mask. Bit 0 = player 1.

## Operation
- Press detection:
  - key_q is a registered copy of the active-high-normalised key vector.
  - press[i] = key_n[i] & ~key_q[i], evaluated every cycle in every state.
  - A key held through arming never generates a press.
- Eligible presses: elig = press & ~foul_expanded. foul_expanded maps foul[0] to keys 0–1 and foul[1] to keys 2–3.
- Round-robin pointer rr (2 bits):
  - The search starts at rr and wraps modulo 4.
  - On each grant, rr is set to grant_id+1.
  - Reset value is 0, so key 0 has highest priority first.
- States:
  - IDLE → ARMED when enable=1.
  - ARMED → GRANT when enable=1 and elig≠0. grant_id and grant_player are latched from the round-robin winner.
  - GRANT: grant_valid=1 and grant_id is held stable. When grant_valid & grant_ready, go to LOCKOUT and load the counter with LOCKOUT_TICKS. If LOCKOUT_TICKS=0, go to ARMED instead.
  - LOCKOUT:
    - Each tick decrements the counter. The tick that brings it to 0 moves the FSM to ARMED on that edge.
    - Any press by player p in LOCKOUT sets foul[p].
- Foul mask clearing: foul clears when the next grant is accepted or when enable falls. Player 2 stays barred until player 1 wins a grant, and vice versa.
- enable=0 in any state:
  - The next state is IDLE and grant_valid drops the following cycle.
  - This aborts an unaccepted grant; rr is unchanged.
  - The lockout counter and foul are cleared.
- Presses in IDLE or GRANT are discarded and never queued.
- Simultaneous presses in ARMED: exactly one wins by round-robin. The rest are dropped, not queued.

## Timing
- Reset values: grant_valid=0, grant_id=0, grant_player=0, lockout=0, foul=0, rr=0, state=IDLE, key_q=released.
- Arming latency: enable high in cycle n means ARMED in cycle n+1. Presses are eligible from cycle n+1.
- Grant latency: a press visible on key in cycle n (state ARMED) gives grant_valid=1 in cycle n+1.
- Handshake:
  - grant_ready is ignored while grant_valid=0.
  - grant_valid can only be removed by acceptance, enable=0 or rst.
  - Acceptance in cycle m means lockout=1 from cycle m+1.
- Lockout edge cases:
  - A tick in the acceptance cycle is not counted.
  - Lockout lasts exactly LOCKOUT_TICKS ticks after acceptance.
  - A press in the same cycle as the final tick is a foul, because the state is still LOCKOUT.
- Counter is 8 bits and never wraps below 0.
- rst mid-operation: all state returns to reset values immediately and asynchronously.

## Structure
- Shared package/header holds:
  - state encodings IDLE=0, ARMED=1, GRANT=2, LOCKOUT=3;
  - the key-to-player map constants (PLAYER_OF_KEY);
  - the LOCKOUT_TICKS default, shared with timer users.
- One sub-module is natural: rr_pick4. It is purely combinational; inputs are elig[3:0] and rr, outputs are win_id and any.
- Edge detection, FSM, lockout counter and foul register stay in the top of this block.

## Test plan
- Key 2 pressed while armed, grant_ready tied 1 → grant_valid pulses 1 cycle after the press, grant_id=2, grant_player=1, lockout=1 for exactly 30 ticks.
- Keys 0 and 3 pressed in the same cycle from reset → key 0 granted. Repeat after lockout → key 3 granted (rr=1).
- Key 1 pressed during lockout → foul=2'b01. Next key 0 press ignored, key 3 press granted, then foul clears on acceptance.
- Key held low before enable rises → no grant. Release then press → grant.
- grant_ready held 0 for 100 cycles → grant_id stable and valid held. Then enable=0 → grant_valid=0 the next cycle, state IDLE, foul=0.
- Assert rst mid-lockout with tick running → all outputs 0 immediately. After release, the first armed press grants normally.
